// File: rtl/boot_loader.sv
// Byte-stream program loader: fills word memory from address 0, then releases the core.
// Optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
module boot_loader #(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        err
);

   localparam int unsigned IW = $clog2(DEPTH + 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {StHdr, StData, StCsum, StRun, StErr} state_e;
   localparam state_e AfterData = StCsum;
`else
   typedef enum logic [2:0] {StHdr, StData, StRun, StErr} state_e;
   localparam state_e AfterData = StRun;
`endif

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [23:0]   asm_q, asm_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] n_q, n_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          done_q, done_d;
   logic [31:0]   word;
   logic          accept;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   sum_q, sum_d;
`endif

   always_comb begin
      in_ready = 1'b0;
      if (rst) begin
         in_ready = (state_q == StHdr) || (state_q == StData)
`ifdef LOADER_CHECKSUM_EN
                    || (state_q == StCsum)
`endif
                    ;
      end
   end

   always_comb begin
      // Incoming byte lands on top; after four bytes the word is little-endian assembled.
      word    = {in_data, asm_q};
      accept  = in_valid && in_ready;
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      idx_d   = idx_q;
      n_d     = n_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = (state_q == StRun);
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (accept) begin
         asm_d = word[31:8];
         cnt_d = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            case (state_q)
               StHdr: begin
                  if (word > 32'(DEPTH)) begin
                     state_d = StErr;
                  end else if (word == 32'd0) begin
                     state_d = AfterData;
                  end else begin
                     n_d     = word[IW-1:0];
                     state_d = StData;
                  end
               end
               StData: begin
                  we_d    = 1'b1;
                  addr_d  = 32'({idx_q, 2'b00});
                  wdata_d = word;
                  idx_d   = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  sum_d   = sum_q + word;
`endif
                  if (idx_d == n_q) state_d = AfterData;
               end
`ifdef LOADER_CHECKSUM_EN
               StCsum: state_d = (word == sum_q) ? StRun : StErr;
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StHdr;
         cnt_q   <= 2'd0;
         asm_q   <= 24'd0;
         idx_q   <= '0;
         n_q     <= '0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   // Release lags RUN by one cycle so the final write commits before the core starts.
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   assign cpu_rst   = done_q;
   assign err       = (state_q == StErr);

endmodule

// File: tb/tb_boot_loader.sv
// Randomized scoreboard bench for boot_loader; adapts to LOADER_CHECKSUM_EN.
module tb_boot_loader;

   localparam int unsigned DEPTH = 64;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready, mem_we, cpu_rst, done, err;
   logic [31:0] mem_addr, mem_wdata;

   int          cyc = 0;
   int          checks = 0;
   int          passed = 0;
   logic [63:0] exp_q[$];
   logic [31:0] words[DEPTH];
   bit          we_seen = 1'b0;
   int          first_we_cyc = 0;

   boot_loader #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the next expected (addr, data) pair.
   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst && mem_we === 1'b1) begin
            if (!we_seen) begin
               we_seen      = 1'b1;
               first_we_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL spurious_we: addr %0h data %0h while no write expected",
                        mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("we_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
               check("we_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
            end
         end
      end
   end

   task automatic check_reset_values();
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_rst", cpu_rst, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      if (chk) check_reset_values();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output int dcyc);
      bit ok = 1'b0;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      dcyc     = cyc;
      for (int t = 0; t < 64; t++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(posedge clk);
      else begin
         checks++;
         $display("FAIL byte_accept: in_ready stayed 0 for byte %0h, required 1", b);
      end
   endtask

   // Reference: header N, then words[0..N-1] at byte addresses 4*i, optional sum trailer.
   task automatic run_load(input logic [31:0] n, input int gap_mode, input bit bad,
                           input bit reset_first, input bit timing_chk);
      logic [7:0]  bytes[$];
      logic [31:0] sum = 32'd0;
      logic [31:0] c;
      bit          hdr_err, exp_err;
      int          dc, start_cyc, g;
      if (reset_first) do_reset(1'b0);
      we_seen = 1'b0;
      start_cyc = 0;
      hdr_err = (n > DEPTH);
      for (int k = 0; k < 4; k++) bytes.push_back(n[8*k +: 8]);
      if (!hdr_err) begin
         for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({32'(i * 4), words[i]});
            sum = sum + words[i];
            for (int k = 0; k < 4; k++) bytes.push_back(words[i][8*k +: 8]);
         end
         if (CSUM) begin
            c = bad ? sum + 32'd1 : sum;
            for (int k = 0; k < 4; k++) bytes.push_back(c[8*k +: 8]);
         end
      end
      exp_err = hdr_err || (CSUM && bad);
      foreach (bytes[j]) begin
         g = 0;
         if (gap_mode == 1 && j == 6) g = 3;
         else if (gap_mode == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 2);
         send_byte(bytes[j], g, dc);
         if (j == 0) start_cyc = dc;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (exp_err) begin
         check("err_set", err, 1);
         check("err_cpu_rst", cpu_rst, 0);
         check("err_in_ready", in_ready, 0);
      end else begin
         if (n != 0 && !CSUM) check("final_we", mem_we, 1);
         check("done_not_early", done, 0);
         @(negedge clk);
         check("done_set", done, 1);
         check("cpu_rst_released", cpu_rst, 1);
         check("run_in_ready", in_ready, 0);
      end
      if (timing_chk) begin
         check("we_seen", we_seen, 1);
         check("first_we_latency", 64'(first_we_cyc - start_cyc), (gap_mode == 1) ? 11 : 8);
      end
      repeat (3) @(negedge clk);
      check("writes_drained", exp_q.size(), 0);
      check("terminal_hold", {done, err}, exp_err ? 2'b01 : 2'b10);
   endtask

   initial begin
      int dc;
      logic [31:0] n;
      do_reset(1'b1);
      #1 check("ready_after_reset", in_ready, 1);

      words[0] = 32'h0050_0113;
      words[1] = 32'h00C0_0193;
      run_load(32'd2, 0, 1'b0, 1'b0, 1'b1);
      run_load(32'd2, 1, 1'b0, 1'b1, 1'b1);
      run_load(32'(DEPTH + 1), 0, 1'b0, 1'b1, 1'b0);
      run_load(32'd0, 0, 1'b0, 1'b1, 1'b0);
      run_load(32'd2, 0, 1'b1, 1'b1, 1'b0);

      // Reset after six accepted bytes, then reload without any further reset.
      do_reset(1'b0);
      send_byte(8'h02, 0, dc);
      send_byte(8'h00, 0, dc);
      send_byte(8'h00, 0, dc);
      send_byte(8'h00, 0, dc);
      send_byte(8'h13, 0, dc);
      send_byte(8'h01, 0, dc);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1 check_reset_values();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_load(32'd2, 0, 1'b0, 1'b0, 1'b1);

      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
         run_load(n, 2, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
      run_load(32'(DEPTH + 1 + $urandom_range(0, 10000)), 2, 1'b0, 1'b1, 1'b0);
      run_load($urandom | 32'h8000_0000, 0, 1'b0, 1'b1, 1'b0);
      run_load(32'h0000_0102, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      run_load(32'(DEPTH), 0, 1'b0, 1'b1, 1'b0);
      run_load(32'd0, 2, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
